// File: rtl/x74151_mux8.sv
// x74151_mux8: registered 8-to-1 data selector (74HC151 style) with active-low strobe.
// Y and Yn come from a single flop, so Yn == ~Y holds in every cycle, including reset.
`default_nettype none

module x74151_mux8 #(
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    En,
  input  logic [SEL_W-1:0]        S,
  input  logic [(2**SEL_W)-1:0]   D,
  output logic                    Y,
  output logic                    Yn
);

  logic y_d;
  logic y_q;

  always_comb begin
    y_d = 1'b0;
    if (!En) begin
      y_d = D[S];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y  = y_q;
  assign Yn = ~y_q;

endmodule

`default_nettype wire

// File: tb/tb_x74151_mux8.sv
// tb_x74151_mux8: directed plus randomized checks of x74151_mux8 against a behavioural model.
`default_nettype none

module tb_x74151_mux8;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic [2:0] S;
  logic [7:0] D;
  logic       Y;
  logic       Yn;

  int checks;
  int failures;

  x74151_mux8 #(.SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .En    (En),
    .S     (S),
    .D     (D),
    .Y     (Y),
    .Yn    (Yn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: strobe high forces 0, otherwise the data bit numbered by S.
  function automatic logic model(input logic en, input int sel, input logic [7:0] data);
    if (en) return 1'b0;
    return ((int'(data) / (1 << sel)) % 2) == 1;
  endfunction

  // Drive inputs just after an edge, then check one edge later.
  task automatic apply(input string tag, input logic en, input logic [2:0] s, input logic [7:0] d);
    logic exp;
    En = en;
    S  = s;
    D  = d;
    exp = model(en, int'(s), d);
    @(posedge clk);
    #1;
    check_val({tag, "_Y"}, Y, exp);
    check_val({tag, "_Yn"}, Yn, ~exp);
  endtask

  initial begin
    logic [7:0] a5;
    checks   = 0;
    failures = 0;
    a5       = 8'hA5;

    // Reset held with a selection that would otherwise give 1
    rst_n = 1'b0;
    En    = 1'b0;
    S     = 3'b101;
    D     = 8'hFF;
    #1;
    check_val("rst_async_Y", Y, 1'b0);
    check_val("rst_async_Yn", Yn, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_hold_Y", Y, 1'b0);
      check_val("rst_hold_Yn", Yn, 1'b1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_release_Y", Y, 1'b1);
    check_val("rst_release_Yn", Yn, 1'b0);

    // Disabled strobe
    apply("dis0", 1'b1, 3'd0, 8'b0000_0001);
    apply("dis1", 1'b1, 3'd1, 8'b0000_0010);

    // Walking select
    apply("walk2", 1'b0, 3'd2, 8'b0000_0100);
    apply("walk3", 1'b0, 3'd3, 8'b0000_1000);
    apply("walk4", 1'b0, 3'd4, 8'b0001_0000);
    apply("walk5", 1'b0, 3'd5, 8'b0010_0000);
    apply("walk5_zero", 1'b0, 3'd5, 8'b1101_1111);

    // Exhaustive select over 8'hA5, expected bits written out independently
    for (int s = 0; s < 8; s++) begin
      En = 1'b0;
      S  = 3'(s);
      D  = a5;
      @(posedge clk);
      #1;
      check_val("exh_Y", Y, a5[s]);
      check_val("exh_Yn", Yn, ~a5[s]);
    end

    // Strobe toggling each cycle, S=7, D=8'h80
    for (int i = 0; i < 4; i++) begin
      apply("toggle", logic'(i % 2), 3'd7, 8'h80);
    end

    // Asynchronous reset between edges while Y=1
    apply("pre_rst", 1'b0, 3'd7, 8'h80);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("midrst_Y", Y, 1'b0);
    check_val("midrst_Yn", Yn, 1'b1);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("midrst_hold_Y", Y, 1'b0);
    apply("post_rst", 1'b0, 3'd7, 8'h80);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      logic       en;
      logic [2:0] s;
      logic [7:0] d;
      en = ($urandom_range(3, 0) == 0);
      s  = 3'($urandom_range(7, 0));
      d  = 8'($urandom);
      if ($urandom_range(15, 0) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rnd_rst_Y", Y, 1'b0);
        check_val("rnd_rst_Yn", Yn, 1'b1);
        rst_n = 1'b1;
      end
      apply("rnd", en, s, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x74151_mux8.md
Name: x74151_mux8

Overview:
Clocked 8-to-1 data selector modelled on the 74HC151: an active-low strobe En gates selection of one of eight data bits D by a 3-bit select S. It drives true output Y and complementary output Yn. Unlike the combinational TTL part, the outputs are registered on clk so the block can sit directly in a synchronous datapath as a single-bit mux stage.

Parameters:
SEL_W, 3, select width; number of data inputs is 2**SEL_W. The default of 3 gives the 74151 geometry, and all values in this spec are for the default.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
En  input  1  strobe, active-low; 1 = selector disabled
S  input  SEL_W (3)  select code, S[2] = MSB
D  input  2**SEL_W (8)  data inputs, D[0] selected by S=0 … D[7] by S=7
Y  output  1  registered selected data (true polarity)
Yn  output  1  registered complement of Y

Behaviour:
- Reset:
  - rst_n low asynchronously forces Y=0 and Yn=1, independent of clk.
  - Outputs hold these values while rst_n is low.
  - First update after release happens on the first rising clk edge with rst_n high.
- Next-state function, evaluated each rising clk edge with rst_n high:
  - En=1 (disabled): Y <= 0, Yn <= 1, regardless of S and D.
  - En=0 (enabled): Y <= D[S], Yn <= ~D[S].
- Latency: exactly one clock. Outputs reflect En/S/D sampled at the previous rising edge. No combinational path from inputs to outputs.
- Invariant: Yn == ~Y at all times, including during and immediately after reset. Both come from one register, or from two registers updated identically.
- S indexes D directly with no decoding gaps; all 8 codes are valid. Unused D bits have no effect.
- S, D and En are sampled only at the clock edge; glitches between edges are invisible.
- Simultaneous changes of En, S and D in one cycle are all taken together at the next edge.
- Reset asserted mid-operation overrides everything immediately. Prior selection is not remembered after release.
- X/Z on an input are not required to be handled specially.
- No handshake; the block accepts a new selection every cycle (throughput 1/clk).

Test Plan:
1. Reset: hold rst_n=0 with En=0, S=3'b101, D=8'hFF and toggle clk -> Y=0, Yn=1 throughout. Then release rst_n -> after the next edge Y=1, Yn=0.
2. Disabled strobe: En=1, S=3'b000, D=8'b0000_0001, then S=3'b001, D=8'b0000_0010 -> Y=0, Yn=1 after each edge, even though the selected bit is 1.
3. Walking select: En=0 with (S=2, D=8'b0000_0100), (S=3, D=8'b0000_1000), (S=4, D=8'b0001_0000), (S=5, D=8'b0010_0000), one per cycle -> Y=1, Yn=0 one cycle after each is applied. Then S=5 with D=8'b1101_1111 -> Y=0, Yn=1.
4. Exhaustive: for all 8 S values and D=8'hA5, En=0 -> Y equals bit S of 8'hA5 (1,0,1,0,0,1,0,1 for S=0..7) one cycle later, with Yn its complement.
5. Latency and toggling: alternate En 0/1 each cycle with S=7, D=8'h80 -> Y sequence 1,0,1,0 lagging En by one edge, with Yn always inverse.
6. Async reset mid-stream: while Y=1, assert rst_n low between clock edges -> Y drops to 0 and Yn rises to 1 immediately, before the next edge.
